// File: rtl/arb4_pkg.sv
// rtl/arb4_pkg.sv - shared types and constants for the 4-way arbiter
// Purpose: FSM state encoding, requester count/index width and round-robin
//          pointer reset value shared by arb4_ctrl and prio_enc4.
// Ports:   none (package).
package arb4_pkg;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    localparam logic [IDW-1:0] RR_PTR_RST = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/arb4_ctrl_prio_enc4.sv
// rtl/arb4_ctrl_prio_enc4.sv - 4-to-2 priority encoder, highest index wins
// Purpose: combinational encoder used by arb4_ctrl to pick a winner.
// Ports:   req_in [3:0] - request vector (bit 3 has highest priority)
//          idx    [1:0] - index of highest set bit, 0 when none set
//          vld          - at least one bit of req_in is set
module prio_enc4
    import arb4_pkg::*;
(
    input  logic [NREQ-1:0] req_in,
    output logic [IDW-1:0]  idx,
    output logic            vld
);

    always_comb begin
        idx = '0;
        vld = |req_in;
        casez (req_in)
            4'b1???: idx = 2'd3;
            4'b01??: idx = 2'd2;
            4'b001?: idx = 2'd1;
            default: idx = 2'd0;
        endcase
    end

endmodule

// File: rtl/arb4_ctrl.sv
// rtl/arb4_ctrl.sv - 4-requester arbiter with bounded grant hold time
// Purpose: grants one of four requesters, holds the grant until done, the
//          owner drops its request, or MAX_HOLD cycles elapse, then inserts
//          a one-cycle RELEASE gap before returning to IDLE.
// Config:  ARB4_ROUND_ROBIN_EN defined   -> rotating priority (rr_ptr)
//          ARB4_ROUND_ROBIN_EN undefined -> fixed priority, index 3 highest
// Ports:   clk          - clock, rising edge
//          rst          - asynchronous active-high reset
//          req [3:0]    - request lines, bit n is requester n
//          done         - owner finished, sampled only in GRANT
//          gnt [3:0]    - registered one-hot grant
//          gnt_id [1:0] - binary owner index, 0 when no owner
//          gnt_vld      - high when gnt is non-zero
//          timeout      - one-cycle pulse in RELEASE after a forced release
module arb4_ctrl
    import arb4_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_vld,
    output logic            timeout
);

    localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

    state_t          state_q,   state_d;
    logic [NREQ-1:0] gnt_q,     gnt_d;
    logic [IDW-1:0]  gnt_id_q,  gnt_id_d;
    logic            gnt_vld_q, gnt_vld_d;
    logic            timeout_q, timeout_d;
    logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;

    logic [NREQ-1:0] enc_in;
    logic [IDW-1:0]  enc_idx;
    logic            enc_vld;
    logic [IDW-1:0]  win_id;

`ifdef ARB4_ROUND_ROBIN_EN
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

    // Rotate so that requester rr_ptr lands on encoder bit 3 (checked first),
    // rr_ptr-1 on bit 2, and so on; the encoder index is then un-rotated.
    always_comb begin
        enc_in = '0;
        for (int j = 0; j < NREQ; j++) begin
            enc_in[j] = req[rr_ptr_q + IDW'(j + 1)];
        end
    end

    assign win_id = rr_ptr_q + enc_idx + 2'd1;
`else
    assign enc_in = req;
    assign win_id = enc_idx;
`endif

    prio_enc4 u_prio_enc4 (
        .req_in (enc_in),
        .idx    (enc_idx),
        .vld    (enc_vld)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        gnt_vld_d  = gnt_vld_q;
        timeout_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
`ifdef ARB4_ROUND_ROBIN_EN
        rr_ptr_d   = rr_ptr_q;
`endif

        unique case (state_q)
            IDLE: begin
                gnt_d      = '0;
                gnt_id_d   = '0;
                gnt_vld_d  = 1'b0;
                hold_cnt_d = '0;
                if (enc_vld) begin
                    state_d   = GRANT;
                    gnt_d     = NREQ'(1) << win_id;
                    gnt_id_d  = win_id;
                    gnt_vld_d = 1'b1;
`ifdef ARB4_ROUND_ROBIN_EN
                    // winner - 1 makes the winner the last one checked next time
                    rr_ptr_d  = win_id - 2'd1;
`endif
                end
            end

            GRANT: begin
                // done wins over the hold limit, so no timeout pulse then
                if (done || !req[gnt_id_q]) begin
                    state_d    = RELEASE;
                    gnt_d      = '0;
                    gnt_id_d   = '0;
                    gnt_vld_d  = 1'b0;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = RELEASE;
                    gnt_d      = '0;
                    gnt_id_d   = '0;
                    gnt_vld_d  = 1'b0;
                    hold_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            RELEASE: begin
                state_d    = IDLE;
                gnt_d      = '0;
                gnt_id_d   = '0;
                gnt_vld_d  = 1'b0;
                hold_cnt_d = '0;
            end

            default: begin
                state_d    = IDLE;
                gnt_d      = '0;
                gnt_id_d   = '0;
                gnt_vld_d  = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            gnt_vld_q  <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            gnt_vld_q  <= gnt_vld_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

`ifdef ARB4_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= RR_PTR_RST;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_vld = gnt_vld_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_arb4_ctrl.sv
// tb/tb_arb4_ctrl.sv - self-checking bench for arb4_ctrl (MAX_HOLD=4)
module tb_arb4_ctrl;
    import arb4_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       vld;
        logic       to;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic       done;
        exp_t       exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    arb4_ctrl #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic [3:0] r, input logic d, input logic [3:0] g,
                           input logic [1:0] id, input logic to);
        vec_t v;
        v.req     = r;
        v.done    = d;
        v.exp.gnt = g;
        v.exp.id  = id;
        v.exp.vld = (g != 4'b0000);
        v.exp.to  = to;
        vecs.push_back(v);
    endtask

    // Called at a negedge: drive one cycle of inputs, compare after the edge.
    task automatic step(input logic [3:0] r, input logic d, input exp_t e, input string tag);
        exp_t got;
        req  = r;
        done = d;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            chk({tag, ".gnt"},     {28'd0, gnt},     {28'd0, got.gnt});
            chk({tag, ".gnt_id"},  {30'd0, gnt_id},  {30'd0, got.id});
            chk({tag, ".gnt_vld"}, {31'd0, gnt_vld}, {31'd0, got.vld});
            chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, got.to});
        end
        chk({tag, ".onehot"}, {31'd0, $onehot0(gnt)}, 32'd1);
        @(negedge clk);
    endtask

    function automatic exp_t mk(input logic [3:0] g, input logic [1:0] id, input logic to);
        exp_t e;
        e.gnt = g;
        e.id  = id;
        e.vld = (g != 4'b0000);
        e.to  = to;
        return e;
    endfunction

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        #12;
        chk("rst.gnt",     {28'd0, gnt},     32'd0);
        chk("rst.gnt_id",  {30'd0, gnt_id},  32'd0);
        chk("rst.gnt_vld", {31'd0, gnt_vld}, 32'd0);
        chk("rst.timeout", {31'd0, timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef ARB4_ROUND_ROBIN_EN
        chk("rst.rr_ptr", {30'd0, dut.rr_ptr_q}, {30'd0, RR_PTR_RST});
        begin
            logic [1:0] seq [5];
            seq[0] = 2'd3; seq[1] = 2'd2; seq[2] = 2'd1; seq[3] = 2'd0; seq[4] = 2'd3;
            for (int i = 0; i < 5; i++) begin
                step(4'b1111, 1'b1, mk(4'b0001 << seq[i], seq[i], 1'b0), $sformatf("rr%0d.grant", i));
                step(4'b1111, 1'b1, mk(4'b0000, 2'd0, 1'b0), $sformatf("rr%0d.release", i));
                step(4'b1111, 1'b1, mk(4'b0000, 2'd0, 1'b0), $sformatf("rr%0d.idle", i));
            end
        end
`else
        // Fixed priority: req 1011 -> 3, done -> RELEASE -> IDLE -> 3 again
        add_vec(4'b1011, 1'b0, 4'b1000, 2'd3, 1'b0);
        add_vec(4'b1011, 1'b1, 4'b0000, 2'd0, 1'b0);
        add_vec(4'b1011, 1'b0, 4'b0000, 2'd0, 1'b0);
        add_vec(4'b1011, 1'b0, 4'b1000, 2'd3, 1'b0);
        // owner drops request -> RELEASE; done ignored in IDLE with req=0
        add_vec(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        add_vec(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
        add_vec(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
        // Timeout: four GRANT cycles, then pulse in RELEASE, then re-grant
        add_vec(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
        add_vec(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
        add_vec(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
        add_vec(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
        add_vec(4'b0010, 1'b0, 4'b0000, 2'd0, 1'b1);
        add_vec(4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0);
        add_vec(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
        // done on the 4th GRANT cycle: normal release, no timeout
        add_vec(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
        add_vec(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
        add_vec(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
        add_vec(4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0);
        add_vec(4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0);
        // req 0100 drops on GRANT cycle 2
        add_vec(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
        add_vec(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
        add_vec(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        add_vec(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        // lowest requester alone, then priority and owner stability
        add_vec(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
        add_vec(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0);
        add_vec(4'b0110, 1'b0, 4'b0000, 2'd0, 1'b0);
        add_vec(4'b0110, 1'b0, 4'b0100, 2'd2, 1'b0);
        add_vec(4'b1110, 1'b0, 4'b0100, 2'd2, 1'b0);
        add_vec(4'b1110, 1'b1, 4'b0000, 2'd0, 1'b0);
        add_vec(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].req, vecs[i].done, vecs[i].exp, $sformatf("vec%0d", i));
        end
`endif

        // Reset in the middle of a grant to requester 2
        step(4'b0100, 1'b0, mk(4'b0100, 2'd2, 1'b0), "midrst.grant");
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.gnt",     {28'd0, gnt},     32'd0);
        chk("midrst.gnt_vld", {31'd0, gnt_vld}, 32'd0);
        chk("midrst.timeout", {31'd0, timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst.state", {30'd0, dut.state_q}, {30'd0, IDLE});
`ifdef ARB4_ROUND_ROBIN_EN
        chk("midrst.rr_ptr", {30'd0, dut.rr_ptr_q}, {30'd0, RR_PTR_RST});
`endif
        @(negedge clk);
        step(4'b0100, 1'b0, mk(4'b0100, 2'd2, 1'b0), "postrst.grant");
        step(4'b0100, 1'b1, mk(4'b0000, 2'd0, 1'b0), "postrst.release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
